// File: rtl/step_controller.sv
// step_controller: run/single-step/N-step/breakpoint clock-enable generator for a debug-controlled CPU
module step_controller #(
  parameter int PC_WIDTH   = 16,
  parameter int CC_WIDTH   = 16,
  parameter int NUM_BP     = 2,
  parameter int RATE_WIDTH = 26
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [1:0]                 mode,
  input  logic                       step_pulse,
  input  logic                       resume,
  input  logic                       halt_req,
  input  logic [7:0]                 step_count,
  input  logic [RATE_WIDTH-1:0]      rate_div,
  input  logic [PC_WIDTH-1:0]        pc,
  input  logic [NUM_BP*PC_WIDTH-1:0] bp_addr,
  input  logic [NUM_BP-1:0]          bp_en,
  output logic                       cpu_en,
  output logic [CC_WIDTH-1:0]        cc,
  output logic [1:0]                 state,
  output logic                       halted,
  output logic [NUM_BP-1:0]          bp_hit
);
  typedef enum logic [1:0] {HALT = 2'd0, RUN = 2'd1, BURST = 2'd2, BREAK = 2'd3} state_t;
  state_t                state_q, state_d;
  logic                  en_q, en_d, skip_q, skip_d;
  logic [CC_WIDTH-1:0]   cc_q;
  logic [NUM_BP-1:0]     hit_q, hit_d, match;
  logic [8:0]            rem_q, rem_d;
  logic [RATE_WIDTH-1:0] rate_q, rate_d;
  logic                  tick;
  genvar i;
  for (i = 0; i < NUM_BP; i++) begin : g_bp
    assign match[i] = bp_en[i] && bp_addr[i*PC_WIDTH +: PC_WIDTH] == pc;
  end
  assign tick   = rate_q == rate_div;
  assign cpu_en = en_q;
  assign cc     = cc_q;
  assign state  = state_q;
  assign bp_hit = hit_q;
  assign halted = state_q == HALT || state_q == BREAK;
  // next state: halt_req beats breakpoints, breakpoints beat rate ticks and steps
  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    rem_d   = rem_q;
    rate_d  = rate_q;
    skip_d  = skip_q;
    hit_d   = hit_q;
    case (state_q)
      HALT:
        if (step_pulse && mode == 2'b01) en_d = 1'b1;
        else if (step_pulse && mode == 2'b10) begin
          state_d = BURST;
          rem_d   = step_count == 8'd0 ? 9'd256 : {1'b0, step_count};
          rate_d  = '0;
        end else if ((step_pulse || resume) && mode[0] == mode[1]) begin
          state_d = RUN;
          rate_d  = '0;
          skip_d  = 1'b0;
        end
      RUN:
        if (halt_req || mode == 2'b01) begin
          state_d = HALT;
          rem_d   = '0;
        end else if (!tick) rate_d = rate_q + 1'b1;
        else begin
          rate_d = '0;
          if (mode == 2'b11 && !skip_q && |match) begin
            hit_d   = hit_q | match;
            state_d = BREAK;
          end else begin
            en_d   = 1'b1;
            skip_d = 1'b0;
          end
        end
      BURST:
        if (halt_req || rem_q == '0) begin
          state_d = HALT;
          rem_d   = '0;
        end else if (!tick) rate_d = rate_q + 1'b1;
        else begin
          rate_d = '0;
          en_d   = 1'b1;
          rem_d  = rem_q - 1'b1;
        end
      BREAK:
        if (step_pulse) begin
          en_d   = 1'b1;
          skip_d = 1'b0;
        end else if (resume) begin
          state_d = RUN;
          rate_d  = '0;
          hit_d   = '0;
          skip_d  = 1'b1;
        end
    endcase
  end
  // state registers; cc counts a pulse in the same cycle cpu_en shows it
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= HALT;
      en_q    <= 1'b0;
      cc_q    <= '0;
      hit_q   <= '0;
      rem_q   <= '0;
      rate_q  <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      cc_q    <= en_d ? cc_q + 1'b1 : cc_q;
      hit_q   <= hit_d;
      rem_q   <= rem_d;
      rate_q  <= rate_d;
      skip_q  <= skip_d;
    end
endmodule

// File: doc/step_controller.md
STEP_CONTROLLER -- requirements
Module: step_controller

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 16, width of the program counter being watched.
REQ-002 SHALL have parameter CC_WIDTH, default 16, width of the clock-enable counter.
REQ-003 SHALL have parameter NUM_BP, default 2, number of breakpoint comparators.
REQ-004 SHALL have parameter RATE_WIDTH, default 26, width of the run-rate divider.
REQ-005 SHALL have ports as follows; one clock; reset is asynchronous and active-high:
- clock  in  1  system clock (CLOCK_50 domain)
- reset  in  1  asynchronous, active-high
- mode  in  2  00 free-run, 01 single-step, 10 N-step, 11 run-to-breakpoint
- step_pulse  in  1  one-cycle debounced step/start request
- resume  in  1  one-cycle request to leave HALT/BREAK and run
- halt_req  in  1  one-cycle request to stop
- step_count  in  8  N for N-step mode
- rate_div  in  RATE_WIDTH  clocks between enables in RUN/BURST, minus 1
- pc  in  PC_WIDTH  current fetch address
- bp_addr  in  NUM_BP*PC_WIDTH  breakpoint addresses, entry i at [i*PC_WIDTH +: PC_WIDTH]
- bp_en  in  NUM_BP  per-breakpoint enable
- cpu_en  out  1  one-cycle pipeline advance enable
- cc  out  CC_WIDTH  count of issued cpu_en pulses
- state  out  2  HALT=0, RUN=1, BURST=2, BREAK=3
- halted  out  1  high in HALT or BREAK
- bp_hit  out  NUM_BP  sticky per-breakpoint hit flags

Function
REQ-006 SHALL assert cpu_en only as a registered single-cycle pulse; never two pulses from one step_pulse in mode 01.
REQ-007 SHALL increment cc by 1 on every cycle cpu_en is high, wrapping from all-ones to 0.
REQ-008 HALT: cpu_en low except as below; step_pulse with mode 01 SHALL issue exactly one cpu_en on the next cycle and remain in HALT.
REQ-009 HALT: step_pulse with mode 10 SHALL load remaining=step_count (0 treated as 256) and enter BURST.
REQ-010 HALT: step_pulse or resume with mode 00 or 11 SHALL enter RUN.
REQ-011 RUN/BURST SHALL use a rate counter: cleared on state entry, cpu_en issued when counter equals rate_div then counter cleared; rate_div=0 gives cpu_en every cycle.
REQ-012 BURST SHALL decrement remaining per cpu_en and enter HALT the cycle after the last pulse (exactly N pulses).
REQ-013 RUN with mode 11: at a tick where cpu_en would issue, if any i has bp_en[i] and bp_addr[i]==pc, SHALL suppress that cpu_en, set bp_hit[i] for every matching i, enter BREAK.
REQ-014 Breakpoints SHALL be ignored in modes 00/01/10 and in BURST.
REQ-015 BREAK: cpu_en low; resume SHALL clear bp_hit and enter RUN with skip-once set, so the first tick in RUN issues cpu_en regardless of breakpoint match; skip-once clears after that pulse.
REQ-016 BREAK: step_pulse SHALL issue one cpu_en (bypassing the match), clear skip-once, remain in BREAK.
REQ-017 halt_req in RUN or BURST SHALL suppress any cpu_en that cycle, clear remaining, enter HALT next cycle; ignored in HALT/BREAK.
REQ-018 Priority per cycle: reset > halt_req > breakpoint > rate tick/step.
REQ-019 mode changing to 01 while in RUN SHALL enter HALT next cycle without a pulse; other mode changes take effect at the next transition only.
REQ-020 Simultaneous step_pulse and resume in HALT SHALL be treated as step_pulse.
REQ-021 halted SHALL be combinational from state; all other outputs registered.

Reset
REQ-022 reset SHALL immediately force state=HALT, cpu_en=0, cc=0, bp_hit=0, remaining=0, rate counter=0, skip-once=0.
REQ-023 reset asserted mid-BURST or mid-RUN SHALL abort without a further cpu_en; after release block sits in HALT awaiting step_pulse/resume.

Verification
V1: mode=01, three step_pulse spaced 5 clocks -> exactly 3 single-cycle cpu_en, cc=3, state stays 0.
V2: mode=10, step_count=4, rate_div=2 -> cpu_en at 3-clock spacing, 4 pulses total, cc=4, then state=0.
V3: mode=11, rate_div=0, bp_en=01, bp_addr[0]=0x0010, pc driven by cpu_en count*4 -> break with pc=0x0010, bp_hit=01, state=3, no pulse at match; resume -> bp_hit=00, pulses resume immediately.
V4: mode=00, rate_div=0, halt_req on cycle 6 of RUN -> no cpu_en that cycle, state=0 next cycle, cc frozen.
V5: mode=10, step_count=0, reset asserted after 100 pulses -> cc=0, state=0, no further cpu_en.
V6: cc preset via 2^CC_WIDTH-1 pulses with CC_WIDTH=4 -> 16th pulse wraps cc to 0.
